sint_delta_integrator: RTL and testbench

//  Inverse of the signed subtractor/differencer path: consumes a stream of signed WIDTH-bit deltas
//  (a - b) and rebuilds the running value by accumulating them into an ACC_WIDTH register.

---
 rtl/sint_integ_pkg.sv | 31 +++
 rtl/sint_sat_add.sv | 36 +++
 rtl/sint_delta_integrator.sv | 73 +++++++
 tb/tb_sint_delta_integrator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sint_integ_pkg.sv
// Shared helpers for the signed delta integrator: overflow modes, output
// register states and width-generic sign-extend / saturation-limit functions.
package sint_integ_pkg;

    localparam int WRAP = 0;
    localparam int SAT  = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Sign-extend the low w bits of v to 64 bits; callers cast to the width they need.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = v;
        for (int i = w; i < 64; i++) begin
            r[i] = v[w-1];
        end
        return r;
    endfunction

    function automatic logic [63:0] sat_max(input int w);
        return (64'(1) << (w - 1)) - 64'(1);
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/sint_sat_add.sv
// Combinational signed add of an ACC_WIDTH base and a WIDTH delta, with
// wrap or clamp on overflow and an overflow indication.
module sint_sat_add
    import sint_integ_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int ACC_WIDTH = 8,
    parameter int SATURATE  = WRAP
) (
    input  logic [ACC_WIDTH-1:0] base,
    input  logic [WIDTH-1:0]     delta,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);

    logic [ACC_WIDTH:0] base_x;
    logic [ACC_WIDTH:0] delta_x;
    logic [ACC_WIDTH:0] full;

    assign base_x  = {base[ACC_WIDTH-1], base};
    assign delta_x = (ACC_WIDTH+1)'(sext(64'(delta), WIDTH));
    assign full    = base_x + delta_x;

    // The top bit of the widened sum is the true sign; disagreement with the
    // next bit means the result does not fit in ACC_WIDTH.
    assign ovf = full[ACC_WIDTH] ^ full[ACC_WIDTH-1];

    always_comb begin
        sum = full[ACC_WIDTH-1:0];
        if (SATURATE == SAT && ovf) begin
            sum = full[ACC_WIDTH] ? ACC_WIDTH'(sat_min(ACC_WIDTH))
                                  : ACC_WIDTH'(sat_max(ACC_WIDTH));
        end
    end

endmodule

// File: rtl/sint_delta_integrator.sv
// Rebuilds a signed running value from a stream of deltas, with a one-entry
// output register, sticky overflow flag and synchronous preload.
//
//   state | meaning
//   EMPTY | out_value already consumed (or never written); in_ready=1
//   FULL  | out_value holds an unconsumed result; held while out_ready=0
module sint_delta_integrator
    import sint_integ_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int ACC_WIDTH = 8,
    parameter int SATURATE  = WRAP
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_delta,
    input  logic                 load,
    input  logic [ACC_WIDTH-1:0] load_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_value,
    output logic                 overflow
);

    out_state_t           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf;
    logic                 accept;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign base      = load ? load_value : acc;

    sint_sat_add #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_add (
        .base  (base),
        .delta (in_delta),
        .sum   (sum),
        .ovf   (ovf)
    );

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state     <= EMPTY;
            acc       <= '0;
            out_value <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            state     <= FULL;
            acc       <= sum;
            out_value <= sum;
            // A load restarts the sticky history, so only this sum can set it.
            overflow  <= load ? ovf : (overflow | ovf);
        end else begin
            if (load) begin
                acc      <= load_value;
                overflow <= 1'b0;
            end
            if (state == FULL && out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_sint_delta_integrator.sv
// Random and directed bench for sint_delta_integrator; wrap and saturate
// instances share stimulus and are checked against an integer model.
module tb_sint_delta_integrator;

    localparam int W  = 3;
    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          ASYNCRESETN = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_delta = '0;
    logic          load = 1'b0;
    logic [AW-1:0] load_value = '0;
    logic          out_ready = 1'b0;

    logic          in_ready_w, out_valid_w, overflow_w;
    logic [AW-1:0] out_value_w;
    logic          in_ready_s, out_valid_s, overflow_s;
    logic [AW-1:0] out_value_s;

    int passed = 0;
    int total  = 0;

    // Model state: index 0 = wrap instance, 1 = saturate instance
    int acc_m [2];
    int val_m [2];
    int ovf_m [2];
    int valid_m;

    always #5 CLK = ~CLK;

    sint_delta_integrator #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(0)) u_wrap (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_delta(in_delta), .load(load), .load_value(load_value), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_value(out_value_w), .overflow(overflow_w)
    );

    sint_delta_integrator #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1)) u_sat (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_delta(in_delta), .load(load), .load_value(load_value), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_value(out_value_s), .overflow(overflow_s)
    );

    task automatic chk(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic int sv(input logic [AW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_m[k] = 0; val_m[k] = 0; ovf_m[k] = 0;
        end
        valid_m = 0;
    endtask

    // Integer view of the rules: sum, detect out-of-range, wrap or clamp.
    task automatic model_step();
        int rdy, acc_en, base, s, o, r;
        rdy    = (valid_m == 0 || out_ready) ? 1 : 0;
        acc_en = (in_valid && rdy == 1) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            if (acc_en == 1) begin
                base = load ? sv(load_value) : acc_m[k];
                s    = base + int'($signed(in_delta));
                o    = (s > 127 || s < -128) ? 1 : 0;
                if (o == 0)      r = s;
                else if (k == 0) r = ((s + 128) & 255) - 128;
                else             r = (s > 127) ? 127 : -128;
                acc_m[k] = r;
                val_m[k] = r;
                ovf_m[k] = load ? o : (ovf_m[k] | o);
            end else if (load) begin
                acc_m[k] = sv(load_value);
                ovf_m[k] = 0;
            end
        end
        if (acc_en == 1)    valid_m = 1;
        else if (out_ready) valid_m = 0;
    endtask

    task automatic compare();
        int rdy;
        rdy = (valid_m == 0 || out_ready) ? 1 : 0;
        chk("in_ready_wrap",  int'(in_ready_w),  rdy);
        chk("in_ready_sat",   int'(in_ready_s),  rdy);
        chk("out_valid_wrap", int'(out_valid_w), valid_m);
        chk("out_valid_sat",  int'(out_valid_s), valid_m);
        chk("out_value_wrap", sv(out_value_w),   val_m[0]);
        chk("out_value_sat",  sv(out_value_s),   val_m[1]);
        chk("overflow_wrap",  int'(overflow_w),  ovf_m[0]);
        chk("overflow_sat",   int'(overflow_s),  ovf_m[1]);
    endtask

    task automatic drive(input bit v, input int d, input bit ld, input int lv, input bit ordy);
        in_valid   = v;
        in_delta   = W'(d);
        load       = ld;
        load_value = AW'(lv);
        out_ready  = ordy;
    endtask

    // Called at a negedge with inputs already applied.
    task automatic tick();
        #1;
        compare();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_out_valid", int'(out_valid_w), 0);
        chk("rst_out_value", sv(out_value_w), 0);
        chk("rst_overflow",  int'(overflow_w), 0);
        ASYNCRESETN = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready_w), 1);
        @(negedge CLK);

        // Streaming
        drive(1, 3, 0, 0, 1);  tick(); chk("stream_3", sv(out_value_w), 3);
        drive(1, -4, 0, 0, 1); tick(); chk("stream_-1", sv(out_value_w), -1);
        drive(1, 2, 0, 0, 1);  tick(); chk("stream_1", sv(out_value_w), 1);
        chk("stream_valid", int'(out_valid_w), 1);
        drive(0, 0, 0, 0, 1);  tick();

        // Backpressure
        drive(0, 0, 1, 0, 1);  tick();
        drive(1, 1, 0, 0, 0);  tick();
        chk("bp_value_1", sv(out_value_w), 1);
        chk("bp_in_ready", int'(in_ready_w), 0);
        drive(1, 2, 0, 0, 0);  tick(); tick();
        chk("bp_held", sv(out_value_w), 1);
        drive(1, 2, 0, 0, 1);  tick();
        chk("bp_value_3", sv(out_value_w), 3);
        drive(0, 0, 0, 0, 1);  tick();

        // Overflow
        drive(0, 0, 1, 126, 1); tick();
        drive(1, 3, 0, 0, 1);   tick();
        chk("ovf_wrap_val", sv(out_value_w), -127);
        chk("ovf_sat_val",  sv(out_value_s), 127);
        chk("ovf_wrap_flag", int'(overflow_w), 1);
        chk("ovf_sat_flag",  int'(overflow_s), 1);
        drive(0, 0, 1, 0, 1);   tick();
        chk("ovf_cleared", int'(overflow_w), 0);

        // Load with accept
        drive(1, -4, 1, -10, 1); tick();
        chk("ldacc_value", sv(out_value_w), -14);
        drive(1, 0, 0, 0, 1);    tick();
        chk("ldacc_acc", sv(out_value_w), -14);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) - 4,
                  $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 1) == 1) ? $urandom_range(120, 127) : $urandom_range(0, 255) - 128,
                  $urandom_range(0, 3) != 0);
            tick();
        end

        // Reset mid-stream
        drive(1, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick();
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("midrst_valid", int'(out_valid_w), 0);
        chk("midrst_valid_sat", int'(out_valid_s), 0);
        model_reset();
        #1 ASYNCRESETN = 1'b1;
        @(negedge CLK);
        drive(1, 1, 0, 0, 1); tick();
        chk("midrst_value", sv(out_value_w), 1);
        drive(0, 0, 0, 0, 1); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
